// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and helpers for the run/pause controller.
// State codes are also used by the host register map.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

    localparam logic [1:0] STATE_ENC_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ENC_RUN   = 2'd1;
    localparam logic [1:0] STATE_ENC_PAUSE = 2'd2;
    localparam logic [1:0] STATE_ENC_DONE  = 2'd3;

    // Pause timer width; never below one bit so a disabled timeout still elaborates.
    function automatic int timer_width(input int pause_to);
        return (pause_to < 1) ? 1 : $clog2(pause_to + 1);
    endfunction

endpackage

// File: rtl/run_ctrl_timer.sv
// Up-counter with synchronous clear, enable and a fixed terminal-count flag.
// Clear dominates enable; the flag is suppressed when TC_EN is 0.
module run_ctrl_timer #(
    parameter int         W     = 8,
    parameter logic [W-1:0] TC  = '0,
    parameter bit         TC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = TC_EN && (count_q == TC);

endmodule

// File: rtl/run_ctrl_fsm.sv
// Run/pause controller: bounded runs with completion pulse, pause timeout,
// abort, and a RUN-cycle counter. All outputs are registered from next state.
module run_ctrl_fsm
    import run_ctrl_pkg::*;
#(
    parameter int  CNT_W    = 16,
    parameter int  PAUSE_TO = 255,
    localparam int TO_W     = timer_width(PAUSE_TO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             stop,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_limit,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] run_cnt,
    output logic [1:0]       state_o
);

    localparam logic [TO_W-1:0] TO_TC = TO_W'((PAUSE_TO == 0) ? 0 : PAUSE_TO - 1);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             timeout_d;
    logic             running_q, paused_q, done_q, timeout_q;
    logic             timer_clr, timer_tc;

    // Timer restarts from zero on every PAUSE entry and whenever PAUSE is left.
    assign timer_clr = (state_q != ST_PAUSE) || (state_d != ST_PAUSE);

    run_ctrl_timer #(
        .W     (TO_W),
        .TC    (TO_TC),
        .TC_EN (PAUSE_TO != 0)
    ) u_pause_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (timer_clr),
        .en_i  (state_q == ST_PAUSE),
        .tc_o  (timer_tc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        limit_d   = limit_q;
        timeout_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        limit_d = run_limit;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Reaching the limit wins over a pause request in the same cycle.
                    if ((limit_q != '0) && (cnt_d == limit_q)) begin
                        state_d = ST_DONE;
                    end else if (stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (go) begin
                        state_d = ST_RUN;
                    end else if (stop) begin
                        state_d = ST_IDLE;
                    end else if (timer_tc) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            limit_q   <= '0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            limit_q   <= limit_d;
            running_q <= (state_d == ST_RUN);
            paused_q  <= (state_d == ST_PAUSE);
            done_q    <= (state_d == ST_DONE);
            timeout_q <= timeout_d;
        end
    end

    assign running = running_q;
    assign paused  = paused_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign run_cnt = cnt_q;
    assign state_o = state_q;

endmodule

// File: doc/run_ctrl_fsm.md
# run_ctrl_fsm

Parametrised run/pause controller, the next generation of the team's go/stop control FSM. It adds a bounded run length with a completion pulse, a pause timeout that falls back to idle, an abort input, and a cycle counter. All outputs are registered and consistent with the exported state in the same cycle. It sits between a host command interface and a datapath that needs a clean `running` enable.

## Interface
- `CNT_W`, 16: width of `run_limit` and `run_cnt`.
- `PAUSE_TO`, 255: pause timeout in cycles; 0 disables timeout.
- `TO_W`, `$clog2(PAUSE_TO+1)` (min 1): pause timer width; derived, not overridden.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `go` in 1: start or resume request, level-sampled.
- `stop` in 1: pause request (RUN) or stop request (PAUSE).
- `abort` in 1: force IDLE from any state.
- `run_limit` in CNT_W: run length in RUN cycles; 0 means unlimited.
- `running` out 1: high exactly when state is RUN.
- `paused` out 1: high exactly when state is PAUSE.
- `done` out 1: one-cycle pulse, high exactly when state is DONE.
- `timeout` out 1: one-cycle pulse on the cycle after a pause timeout.
- `run_cnt` out CNT_W: RUN cycles elapsed in the current run.
- `state_o` out 2: encoded current state.

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Reset values: state IDLE; `running`, `paused`, `done`, `timeout` all 0; `run_cnt` 0; pause timer 0; limit register 0.
- Priority in every state: `abort` first. Abort moves to IDLE, clears the pause timer, and produces no `done` or `timeout`. `run_cnt` holds.
- **IDLE**
  - `go` -> RUN.
  - On this transition: `run_cnt` <- 0 and `run_limit` is latched. Later changes to `run_limit` are ignored until the next IDLE->RUN.
- **RUN**
  - `run_cnt` increments every RUN cycle; in unlimited mode it wraps modulo 2^CNT_W.
  - If the latched limit ≠ 0 and `run_cnt`+1 == limit -> DONE. This takes priority over `stop`.
  - Else `stop` -> PAUSE.
- **PAUSE**
  - `run_cnt` holds; the pause timer increments each cycle.
  - `go` -> RUN. `run_cnt` is preserved and the timer is cleared. `go` beats `stop`.
  - Else `stop` -> IDLE.
  - Else if PAUSE_TO ≠ 0 and timer == PAUSE_TO-1 -> IDLE, with `timeout` = 1 for the next cycle.
- **DONE**
  - Lasts exactly one cycle, then -> IDLE.
  - `go` is ignored in this cycle; it must be seen in IDLE to restart.
  - `run_cnt` holds its final value (== limit) until the next run starts.
- Limit of 1: exactly one RUN cycle, then DONE.

## Timing
- Input sampled in cycle N -> new state and all outputs visible in cycle N+1. No combinational input-to-output paths.
- `running` / `paused` / `done` are decoded from the next state and registered, so they never lag `state_o`.
- `run_cnt` value k is visible during the (k+1)-th RUN cycle: 0 in the first RUN cycle.
- Pause timeout: entering PAUSE in cycle P with no `go`/`stop` gives state IDLE and `timeout`=1 in cycle P+PAUSE_TO.
- Reset asserted mid-run: all outputs go to reset values immediately (async). Release is synchronised externally; the first active edge after release is in IDLE.

## Structure
- Package `run_ctrl_pkg`: `run_state_t` enum (logic [1:0], values above), plus state-encoding constants shared with the host register map.
- One sub-module, `run_ctrl_timer`: a TO_W-bit counter with clear/enable/terminal-count, used for the pause timer. The run counter is inline.
- Single module otherwise; next-state logic and registered outputs in one clocked process are acceptable.

## Test plan
- Reset then `go` pulse with `run_limit`=5 -> `running` high for 5 cycles with `run_cnt` 0..4, then `done`=1 for one cycle with `run_cnt`=5, then IDLE.
- `run_limit`=0, `go`, hold for 2^CNT_W+3 cycles (CNT_W=4 build) -> no `done`; `run_cnt` wraps 15->0.
- RUN 3 cycles, `stop` -> PAUSE 10 cycles, `go` -> RUN resumes with `run_cnt`=3; `go`+`stop` together in PAUSE -> RUN.
- PAUSE_TO=8: enter PAUSE, idle inputs -> IDLE with `timeout`=1 exactly 8 cycles after PAUSE entry. PAUSE_TO=0 -> stays in PAUSE for 1000 cycles.
- `run_limit`=4 with `stop` asserted on the 4th RUN cycle -> DONE, not PAUSE. Change `run_limit` mid-run -> no effect.
- `abort` in each of RUN, PAUSE, DONE -> IDLE next cycle, no `done`/`timeout`. Async `rst_n` mid-RUN -> all outputs 0 immediately.
